// File: rtl/display_arbiter_if.sv
// Display-sharing bus between the requesters and the arbiter that owns the
// two-digit 7-segment display.
interface display_arbiter_if #(
    parameter int NUM_REQ = 4
);
    localparam int OWN_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]   i_req;
    logic [8*NUM_REQ-1:0] i_value;
    logic                 i_advance;
    logic [NUM_REQ-1:0]   o_grant;
    logic [OWN_W-1:0]     o_owner;
    logic                 o_valid;
    logic [3:0]           o_digit1;
    logic [3:0]           o_digit2;

    // Arbiter side.
    modport slave (
        input  i_req,
        input  i_value,
        input  i_advance,
        output o_grant,
        output o_owner,
        output o_valid,
        output o_digit1,
        output o_digit2
    );

    // Requester / system side.
    modport master (
        output i_req,
        output i_value,
        output i_advance,
        input  o_grant,
        input  o_owner,
        input  o_valid,
        input  o_digit1,
        input  o_digit2
    );
endinterface

// File: rtl/display_arbiter.sv
// Round-robin owner of the two-digit display with a minimum hold time; the
// advance pulse rotates early when another requester is waiting.
module display_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int HOLD_CYCLES = 25000000
) (
    input  logic                clock,
    input  logic                reset,
    display_arbiter_if.slave    bus
);
    localparam int OWN_W = $clog2(NUM_REQ);
    localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [OWN_W-1:0] LAST_RST = OWN_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        FREE = 2'd2
    } state_t;

    typedef struct packed {
        logic             found;
        logic [OWN_W-1:0] idx;
    } pick_t;

    // First requester after 'last' in circular order.
    function automatic pick_t rr_pick(input logic [NUM_REQ-1:0] req,
                                      input logic [OWN_W-1:0]   last);
        pick_t p;
        int    k;
        p.found = 1'b0;
        p.idx   = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            k = (int'(last) + i) % NUM_REQ;
            if (!p.found && req[k]) begin
                p.found = 1'b1;
                p.idx   = OWN_W'(k);
            end
        end
        return p;
    endfunction

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [OWN_W-1:0]     last_q, last_d;
    logic [OWN_W-1:0]     owner_q, owner_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic                 valid_q, valid_d;
    logic [7:0]           value_q, value_d;

    pick_t                pick_any;
    pick_t                pick_other;
    logic                 do_grant;
    logic [OWN_W-1:0]     sel_idx;
    logic                 owner_req;
    logic [7:0]           owner_value;

    always_comb begin
        pick_any    = rr_pick(bus.i_req, last_q);
        pick_other  = rr_pick(bus.i_req & ~grant_q, last_q);
        owner_req   = bus.i_req[owner_q];
        owner_value = bus.i_value[8*int'(owner_q) +: 8];
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // can leave a signal unassigned and infer a latch.
        state_d  = state_q;
        cnt_d    = cnt_q;
        last_d   = last_q;
        owner_d  = owner_q;
        grant_d  = grant_q;
        valid_d  = valid_q;
        value_d  = value_q;
        do_grant = 1'b0;
        sel_idx  = '0;

        unique case (state_q)
            IDLE: begin
                if (pick_any.found) begin
                    do_grant = 1'b1;
                    sel_idx  = pick_any.idx;
                end
            end
            HOLD: begin
                if (bus.i_advance && pick_other.found) begin
                    do_grant = 1'b1;
                    sel_idx  = pick_other.idx;
                end else begin
                    if (owner_req) begin
                        value_d = owner_value;
                    end
                    if (cnt_q == CNT_MAX) begin
                        state_d = FREE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            FREE: begin
                // Hold time is spent: any other waiting requester takes over,
                // with or without an advance pulse.
                if (pick_other.found) begin
                    do_grant = 1'b1;
                    sel_idx  = pick_other.idx;
                end else if (owner_req) begin
                    value_d = owner_value;
                end else begin
                    state_d = IDLE;
                    grant_d = '0;
                    valid_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
                valid_d = 1'b0;
            end
        endcase

        if (do_grant) begin
            state_d          = HOLD;
            cnt_d            = '0;
            last_d           = sel_idx;
            owner_d          = sel_idx;
            grant_d          = '0;
            grant_d[sel_idx] = 1'b1;
            valid_d          = 1'b1;
            value_d          = bus.i_value[8*int'(sel_idx) +: 8];
        end
    end

    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            last_q  <= LAST_RST;
            owner_q <= '0;
            grant_q <= '0;
            valid_q <= 1'b0;
            value_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            owner_q <= owner_d;
            grant_q <= grant_d;
            valid_q <= valid_d;
            value_q <= value_d;
        end
    end

    assign bus.o_grant  = grant_q;
    assign bus.o_owner  = owner_q;
    assign bus.o_valid  = valid_q;
    assign bus.o_digit1 = value_q[7:4];
    assign bus.o_digit2 = value_q[3:0];

endmodule

// File: tb/tb_display_arbiter.sv
// Directed bench for display_arbiter with NUM_REQ=4, HOLD_CYCLES=4; inputs
// change and outputs are sampled on the falling clock edge.
module tb_display_arbiter;
    localparam int NUM_REQ = 4;
    localparam int HOLD    = 4;

    logic clock;
    logic reset;
    int   n_checks;
    int   n_fail;

    display_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

    display_arbiter #(
        .NUM_REQ    (NUM_REQ),
        .HOLD_CYCLES(HOLD)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [3:0] grant,
                             input logic [1:0] owner, input logic valid,
                             input logic [3:0] d1, input logic [3:0] d2);
        check({tag, ".grant"}, 32'(bus.o_grant), 32'(grant));
        check({tag, ".owner"}, 32'(bus.o_owner), 32'(owner));
        check({tag, ".valid"}, 32'(bus.o_valid), 32'(valid));
        check({tag, ".d1"},    32'(bus.o_digit1), 32'(d1));
        check({tag, ".d2"},    32'(bus.o_digit2), 32'(d2));
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic do_reset();
        bus.i_req     = '0;
        bus.i_advance = 1'b0;
        reset         = 1'b1;
        step(2);
        reset         = 1'b0;
    endtask

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        bus.i_req     = '0;
        bus.i_value   = '0;
        bus.i_advance = 1'b0;
        reset         = 1'b1;
        step(2);
        check_out("reset", 4'b0000, 2'd0, 1'b0, 4'h0, 4'h0);
        reset = 1'b0;

        // Single requester: grant latency and value tracking.
        bus.i_value[7:0] = 8'h3A;
        bus.i_req        = 4'b0001;
        step(1);
        check_out("first_grant", 4'b0001, 2'd0, 1'b1, 4'h3, 4'hA);
        bus.i_value[7:0] = 8'h47;
        step(1);
        check_out("track", 4'b0001, 2'd0, 1'b1, 4'h4, 4'h7);

        // Owner drops its request at hold cycle 1: digits freeze, then blank.
        bus.i_req        = 4'b0000;
        bus.i_value[7:0] = 8'h99;
        step(2);
        check_out("frozen_hold", 4'b0001, 2'd0, 1'b1, 4'h4, 4'h7);
        step(1);
        check_out("frozen_free", 4'b0001, 2'd0, 1'b1, 4'h4, 4'h7);
        step(1);
        check_out("release_idle", 4'b0000, 2'd0, 1'b0, 4'h4, 4'h7);

        // Two steady requesters alternate every HOLD+1 cycles with no gap.
        do_reset();
        bus.i_value[15:0] = 16'h3412;
        bus.i_req         = 4'b0011;
        for (int i = 1; i <= 11; i++) begin
            step(1);
            check($sformatf("alt%0d.grant", i), 32'(bus.o_grant),
                  (i <= 5 || i == 11) ? 32'h1 : 32'h2);
            check($sformatf("alt%0d.valid", i), 32'(bus.o_valid), 32'h1);
            if (i == 6) check_out("alt_handoff", 4'b0010, 2'd1, 1'b1, 4'h3, 4'h4);
        end

        // Advance with nobody else waiting is ignored; with req3 waiting it
        // hands off immediately, and the hold counter was not disturbed.
        do_reset();
        bus.i_value   = 32'hC9_00_00_55;
        bus.i_req     = 4'b0001;
        step(1);
        check_out("adv_own", 4'b0001, 2'd0, 1'b1, 4'h5, 4'h5);
        bus.i_advance = 1'b1;
        step(1);
        check_out("adv_ignored", 4'b0001, 2'd0, 1'b1, 4'h5, 4'h5);
        bus.i_req     = 4'b1001;
        step(1);
        bus.i_advance = 1'b0;
        check_out("adv_handoff", 4'b1000, 2'd3, 1'b1, 4'hC, 4'h9);
        step(4);
        check("adv_hold_end.grant", 32'(bus.o_grant), 32'h8);
        step(1);
        check_out("adv_return", 4'b0001, 2'd0, 1'b1, 4'h5, 4'h5);

        // All four requesting: strict rotation 0,1,2,3,0 with no blank cycle.
        do_reset();
        bus.i_value = 32'h44_33_22_11;
        bus.i_req   = 4'b1111;
        for (int i = 1; i <= 21; i++) begin
            step(1);
            check($sformatf("rr%0d.owner", i), 32'(bus.o_owner),
                  32'(((i - 1) / 5) % 4));
            check($sformatf("rr%0d.valid", i), 32'(bus.o_valid), 32'h1);
        end
        check_out("rr_wrap", 4'b0001, 2'd0, 1'b1, 4'h1, 4'h1);

        // Asynchronous reset mid-HOLD, then requester 0 wins again.
        step(1);
        check("pre_rst.grant", 32'(bus.o_grant), 32'h1);
        #2 reset = 1'b1;
        #1 check_out("async_rst", 4'b0000, 2'd0, 1'b0, 4'h0, 4'h0);
        step(2);
        reset = 1'b0;
        step(1);
        check_out("post_rst", 4'b0001, 2'd0, 1'b1, 4'h1, 4'h1);
        step(1);
        check("post_rst_hold.owner", 32'(bus.o_owner), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end
endmodule
